nnrv_mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter; responder on the MEM-stage data-RAM bus (addr/en/mask/data, 32-bit).

---
 rtl/nnrv_mmio_uart_tx.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_nnrv_mmio_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nnrv_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// nnrv_mmio_uart_tx
//
// Memory-mapped 8N1 UART transmitter. It sits on the MEM-stage data-RAM bus and
// is decoded alongside the data RAM. CPU stores push bytes into a small TX FIFO,
// and a serialiser drains the FIFO onto o_tx. CPU loads return status and the
// baud divisor.
//
// Register map (word offset = addr[3:2], addr[1:0] ignored):
//   0 TXDATA  W: wr_mask[0] pushes wr_data[7:0]; reads 0
//   1 STATUS  R: {count[3:0], ovf, empty, full, busy}; W: wr_mask[0] & data[3] clears ovf
//   2 BAUDDIV RW: bits [15:0], byte-write per wr_mask[1:0]; clk cycles per bit
//   3 reserved: reads 0, writes ignored
//
// Ports:
//   i_clk      clock, all state on the rising edge
//   i_rst      asynchronous active-low reset
//   i_rd_addr  load byte address        i_rd_en   load strobe
//   i_rd_mask  load byte enables (full word is always returned)
//   o_rd_data  registered load data, 0 when no hit load in the previous cycle
//   i_wr_addr  store byte address       i_wr_en   store strobe
//   i_wr_mask  store byte enables       i_wr_data store data
//   o_tx       serial line, idle high
//   o_irq      FIFO empty and serialiser idle (registered)
// -----------------------------------------------------------------------------
module nnrv_mmio_uart_tx #(
  parameter int unsigned                  ADDR_WIDTH  = 8,
  parameter int unsigned                  XLEN        = 32,
  parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR   = 8'hF0,
  parameter int unsigned                  FIFO_DEPTH  = 4,
  parameter logic [15:0]                  DEFAULT_DIV = 16'd8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_rd_en,
  input  logic [3:0]            i_rd_mask,
  output logic [XLEN-1:0]       o_rd_data,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic                  i_wr_en,
  input  logic [3:0]            i_wr_mask,
  input  logic [XLEN-1:0]       i_wr_data,
  output logic                  o_tx,
  output logic                  o_irq
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] OffTxData = 2'd0;
  localparam logic [1:0] OffStatus = 2'd1;
  localparam logic [1:0] OffBaud   = 2'd2;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       rd_hit, wr_hit;
  logic [1:0] rd_off, wr_off;
  logic       txdata_wr, ovf_clr, baud_wr_lo, baud_wr_hi;

  assign rd_hit = i_rd_en && (i_rd_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign wr_hit = i_wr_en && (i_wr_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign rd_off = i_rd_addr[3:2];
  assign wr_off = i_wr_addr[3:2];

  assign txdata_wr  = wr_hit && (wr_off == OffTxData) && i_wr_mask[0];
  assign ovf_clr    = wr_hit && (wr_off == OffStatus) && i_wr_mask[0] && i_wr_data[3];
  assign baud_wr_lo = wr_hit && (wr_off == OffBaud) && i_wr_mask[0];
  assign baud_wr_hi = wr_hit && (wr_off == OffBaud) && i_wr_mask[1];

  // Bits of the bus that this block never looks at.
  logic unused_bits;
  assign unused_bits = ^{i_rd_mask, i_rd_addr[1:0], i_wr_addr[1:0], i_wr_mask[3:2],
                         i_wr_data[XLEN-1:16]};

  // ---------------------------------------------------------------------------
  // Registers: baud divisor and sticky overflow flag
  // ---------------------------------------------------------------------------
  logic [15:0] baud_q, baud_d;
  logic        ovf_q, ovf_d;
  logic        overflow;

  always_comb begin
    baud_d = baud_q;
    if (baud_wr_lo) baud_d[7:0]  = i_wr_data[7:0];
    if (baud_wr_hi) baud_d[15:8] = i_wr_data[15:8];
  end

  // Set beats clear when both land in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)  ovf_d = 1'b0;
    if (overflow) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      baud_q <= DEFAULT_DIV;
      ovf_q  <= 1'b0;
    end else begin
      baud_q <= baud_d;
      ovf_q  <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            fifo_empty, fifo_full;
  logic            push, pop;
  logic [7:0]      fifo_head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_head  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a byte when the serialiser pops in the same cycle.
  assign push     = txdata_wr && (!fifo_full || pop);
  assign overflow = txdata_wr && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wr_data[7:0];
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] tick_q, tick_d;    // cycles spent in the current bit
  logic [15:0] div_q, div_d;      // bit period latched for the current frame
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        bit_done;
  logic        busy;

  assign bit_done = (tick_q == div_q - 16'd1);

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty)                   state_d = StStart;
      StStart: if (bit_done)                      state_d = StData;
      StData:  if (bit_done && bit_idx_q == 3'd7) state_d = StStop;
      StStop:  if (bit_done)                      state_d = StIdle;
      default:                                    state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    o_tx = 1'b1;
    busy = 1'b1;
    pop  = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        pop  = !fifo_empty;
      end
      StStart: o_tx = 1'b0;
      StData:  o_tx = shift_q[0];
      StStop:  o_tx = 1'b1;
      default: o_tx = 1'b1;
    endcase
  end

  // Frame datapath: bit timer, bit index, shift register, latched divisor.
  always_comb begin
    tick_d    = tick_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    div_d     = div_q;
    if (state_q == StIdle || bit_done) tick_d = '0;
    if (pop) begin
      shift_d = fifo_head;
      // A zero divisor behaves as one cycle per bit.
      div_d   = (baud_q == 16'd0) ? 16'd1 : baud_q;
    end
    if (bit_done) begin
      if (state_q == StStart) bit_idx_d = 3'd0;
      if (state_q == StData) begin
        bit_idx_d = bit_idx_q + 3'd1;
        shift_d   = {1'b0, shift_q[7:1]};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tick_q    <= '0;
      div_q     <= 16'd1;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      tick_q    <= tick_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt: registered from next-state so it never depends on bus timing
  // beyond the edge that updates the FIFO and FSM.
  // ---------------------------------------------------------------------------
  logic irq_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      irq_q <= 1'b1;
    end else begin
      irq_q <= (count_d == '0) && (state_d == StIdle);
    end
  end

  assign o_irq = irq_q;

  // ---------------------------------------------------------------------------
  // Load path: returns pre-edge state, so a same-cycle store is not visible.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [7:0]      status;

  assign status = {4'(count_q), ovf_q, fifo_empty, fifo_full, busy};

  always_comb begin
    rd_data_d = '0;
    if (rd_hit) begin
      unique case (rd_off)
        OffStatus: rd_data_d[7:0]  = status;
        OffBaud:   rd_data_d[15:0] = baud_q;
        default:   rd_data_d       = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_nnrv_mmio_uart_tx.sv
module tb_nnrv_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_mask = 4'hF;
  logic [31:0] rd_data;
  logic [7:0]  wr_addr = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_mask = '0;
  logic [31:0] wr_data = '0;
  logic        tx;
  logic        irq;

  nnrv_mmio_uart_tx #(
    .ADDR_WIDTH (8),
    .XLEN       (32),
    .BASE_ADDR  (8'hF0),
    .FIFO_DEPTH (4),
    .DEFAULT_DIV(16'd8)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .i_rd_addr(rd_addr),
    .i_rd_en  (rd_en),
    .i_rd_mask(rd_mask),
    .o_rd_data(rd_data),
    .i_wr_addr(wr_addr),
    .i_wr_en  (wr_en),
    .i_wr_mask(wr_mask),
    .i_wr_data(wr_data),
    .o_tx     (tx),
    .o_irq    (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line trace, one sample per cycle on the falling edge.
  logic trace[$];
  logic rec = 1'b0;
  always @(negedge clk) if (rec) trace.push_back(tx);

  // All bus ops start and end on a falling edge.
  task automatic bus_op(input bit do_rd, input logic [7:0] raddr, input bit do_wr,
                        input logic [7:0] waddr, input logic [3:0] mask,
                        input logic [31:0] data, output logic [31:0] rdata);
    rd_en = do_rd; rd_addr = raddr;
    wr_en = do_wr; wr_addr = waddr; wr_mask = mask; wr_data = data;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    rdata = rd_data;
  endtask

  task automatic store(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] dummy;
    bus_op(1'b0, 8'h00, 1'b1, a, m, d, dummy);
  endtask

  task automatic load(input logic [7:0] a, output logic [31:0] d);
    bus_op(1'b1, a, 1'b0, 8'h00, 4'h0, 32'h0, d);
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (irq !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " drain"}, (cyc < 3000) ? 32'd1 : 32'd0, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Reference: each frame is start(0), 8 data bits LSB first, stop(1), each
  // held for div cycles; consecutive frames are separated by one idle cycle.
  task automatic check_frames(input string name, input int divs[$], input logic [7:0] bytes[$]);
    int idx = 0;
    int bad;
    int gap;
    logic expbit;
    while (idx < trace.size() && trace[idx] === 1'b1) idx++;
    foreach (bytes[k]) begin
      if (k > 0) begin
        gap = 0;
        while (idx < trace.size() && trace[idx] === 1'b1) begin
          gap++;
          idx++;
        end
        check($sformatf("%s gap%0d", name, k), gap, 1);
      end
      bad = 0;
      for (int b = 0; b < 10; b++) begin
        expbit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bytes[k][b-1];
        for (int c = 0; c < divs[k]; c++) begin
          if (idx >= trace.size() || trace[idx] !== expbit) bad++;
          idx++;
        end
      end
      check($sformatf("%s frame%0d byte 0x%0h bad-cycles", name, k, bytes[k]), bad, 0);
    end
    bad = 0;
    while (idx < trace.size()) begin
      if (trace[idx] !== 1'b1) bad++;
      idx++;
    end
    check({name, " tail idle"}, bad, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] r;
    logic [7:0]  bq[$];
    int          dq[$];
    int          n, div, acc, cnt;
    logic [7:0]  b;

    vecs.push_back('{0, 8'hF4, 4'h0, 32'h0,        32'h04,   "status_reset"});
    vecs.push_back('{0, 8'hF8, 4'h0, 32'h0,        32'h08,   "baud_reset"});
    vecs.push_back('{0, 8'hF0, 4'h0, 32'h0,        32'h00,   "txdata_read"});
    vecs.push_back('{0, 8'hFC, 4'h0, 32'h0,        32'h00,   "reserved_read"});
    vecs.push_back('{1, 8'hF8, 4'h3, 32'h1234,     32'h0,    ""});
    vecs.push_back('{0, 8'hF8, 4'h0, 32'h0,        32'h1234, "baud_full"});
    vecs.push_back('{1, 8'hF8, 4'h2, 32'h5600,     32'h0,    ""});
    vecs.push_back('{0, 8'hFA, 4'h0, 32'h0,        32'h5634, "baud_hi_byte"});
    vecs.push_back('{1, 8'hF8, 4'h1, 32'hAB78,     32'h0,    ""});
    vecs.push_back('{0, 8'hF8, 4'h0, 32'h0,        32'h5678, "baud_lo_byte"});
    vecs.push_back('{1, 8'hF8, 4'hC, 32'hFFFFFFFF, 32'h0,    ""});
    vecs.push_back('{0, 8'hF8, 4'h0, 32'h0,        32'h5678, "baud_upper_mask"});
    vecs.push_back('{1, 8'hEC, 4'hF, 32'hFFFFFFFF, 32'h0,    ""});
    vecs.push_back('{1, 8'hE8, 4'hF, 32'h0,        32'h0,    ""});
    vecs.push_back('{0, 8'hF8, 4'h0, 32'h0,        32'h5678, "baud_after_miss"});
    vecs.push_back('{0, 8'hE8, 4'h0, 32'h0,        32'h0,    "miss_read"});
    vecs.push_back('{0, 8'hEC, 4'h0, 32'h0,        32'h0,    "miss_read_base_m4"});
    vecs.push_back('{1, 8'hE0, 4'hF, 32'h55,       32'h0,    ""});
    vecs.push_back('{1, 8'hFC, 4'hF, 32'hFFFFFFFF, 32'h0,    ""});
    vecs.push_back('{0, 8'hF4, 4'h0, 32'h0,        32'h04,   "status_after_miss"});
    vecs.push_back('{0, 8'hFC, 4'h0, 32'h0,        32'h0,    "reserved_after_wr"});
    vecs.push_back('{1, 8'hF8, 4'h3, 32'h0008,     32'h0,    ""});
    vecs.push_back('{0, 8'hF8, 4'h0, 32'h0,        32'h08,   "baud_restore"});

    // Reset state
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset irq", irq, 1);
    check("reset rd_data", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Register vectors
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) store(vecs[i].addr, vecs[i].data, vecs[i].mask);
      else begin
        load(vecs[i].addr, r);
        check(vecs[i].name, r, vecs[i].exp);
      end
    end
    @(negedge clk);
    check("rd_data idle zero", rd_data, 0);
    check("irq after misses", irq, 1);

    // Single frame 0xA5 at the default divisor
    trace.delete(); rec = 1'b1;
    store(8'hF0, 32'hA5, 4'h1);
    check("irq busy", irq, 0);
    wait_idle("a5");
    rec = 1'b0;
    check("irq back", irq, 1);
    bq = '{8'hA5}; dq = '{8};
    check_frames("a5", dq, bq);

    // Six back-to-back stores at divisor 2: one popped, four queued, one dropped
    store(8'hF8, 32'h2, 4'h3);
    trace.delete(); rec = 1'b1;
    for (int i = 0; i < 6; i++) store(8'hF0, 32'h11 * (i + 1), 4'h1);
    load(8'hF4, r);
    check("burst status", r, 32'h4B);
    store(8'hF4, 32'h08, 4'h1);
    load(8'hF4, r);
    check("ovf cleared", r, 32'h43);
    wait_idle("burst");
    rec = 1'b0;
    load(8'hF4, r);
    check("burst drained", r, 32'h04);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}; dq = '{2, 2, 2, 2, 2};
    check_frames("burst", dq, bq);

    // Randomised bursts against the frame model
    for (int it = 0; it < 8; it++) begin
      div = $urandom_range(0, 4);
      n   = $urandom_range(1, 6);
      store(8'hF8, div, 4'h3);
      trace.delete(); rec = 1'b1;
      bq.delete(); dq.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        store(8'hF0, {24'h0, b}, 4'h1);
        if (i <= 4) begin
          bq.push_back(b);
          dq.push_back((div == 0) ? 1 : div);
        end
      end
      acc = (n > 5) ? 5 : n;
      cnt = acc - 1;
      load(8'hF4, r);
      check($sformatf("rnd%0d status", it), r,
            {24'h0, 4'(cnt), (n > 5) ? 1'b1 : 1'b0, (cnt == 0) ? 1'b1 : 1'b0,
             (cnt == 4) ? 1'b1 : 1'b0, 1'b1});
      wait_idle($sformatf("rnd%0d", it));
      rec = 1'b0;
      check_frames($sformatf("rnd%0d", it), dq, bq);
      store(8'hF4, 32'h08, 4'h1);
    end

    // Divisor 0 then 3 written mid-frame: only the next frame uses 3
    store(8'hF8, 32'h0, 4'h3);
    trace.delete(); rec = 1'b1;
    store(8'hF0, 32'h3C, 4'h1);
    store(8'hF8, 32'h3, 4'h3);
    store(8'hF0, 32'hC9, 4'h1);
    wait_idle("divchg");
    rec = 1'b0;
    bq = '{8'h3C, 8'hC9}; dq = '{1, 3};
    check_frames("divchg", dq, bq);

    // Same-cycle load and store to BAUDDIV returns the old value
    store(8'hF8, 32'h8, 4'h3);
    bus_op(1'b1, 8'hF8, 1'b1, 8'hF8, 4'h3, 32'h0010, r);
    check("load old baud", r, 32'h08);
    load(8'hF8, r);
    check("load new baud", r, 32'h10);
    store(8'hF8, 32'h1200, 4'h2);
    load(8'hF8, r);
    check("baud mask 0010", r, 32'h1210);

    // Reset mid-frame with a byte still queued
    store(8'hF8, 32'h5, 4'h3);
    store(8'hF0, 32'h00, 4'h1);
    store(8'hF0, 32'h00, 4'h1);
    repeat (8) @(negedge clk);
    check("tx low mid-frame", tx, 0);
    #2 rst_n = 1'b0;
    #1 check("reset tx immediate", tx, 1);
    check("reset irq immediate", irq, 1);
    @(negedge clk);
    rst_n = 1'b1;
    trace.delete(); rec = 1'b1;
    load(8'hF4, r);
    check("status after reset", r, 32'h04);
    load(8'hF8, r);
    check("baud after reset", r, 32'h08);
    repeat (40) @(negedge clk);
    rec = 1'b0;
    bq.delete(); dq.delete();
    check_frames("post-reset", dq, bq);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
